// File: rtl/fixed_point_pkg.sv
// Shared types and constants for the fixed-point add/subtract datapath.
// Provides the flag bundle and signed saturation limits for any width.
package fixed_point_pkg;

    localparam int FX_MAX_W = 64;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic negative;
        logic zero;
    } fx_flags_t;

    // Largest positive two's-complement value of width w (011..1).
    function automatic logic [FX_MAX_W-1:0] fx_max(input int w);
        logic [FX_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FX_MAX_W; i++) begin
            if (i < w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative two's-complement value of width w (100..0).
    function automatic logic [FX_MAX_W-1:0] fx_min(input int w);
        logic [FX_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FX_MAX_W; i++) begin
            if (i == w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One carry-chain slice: sum/co = a + b + ci (combinational).
// Ports: a, b (SEG bits), ci -> sum (SEG bits), co.
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/pipelined_fixed_adder.sv
// Pipelined signed add/subtract with saturation, flags and in-order tags.
// Ports: clk, rst_n (sync, low); in_valid/in_ready, a, b, is_subtract,
//   saturate, in_tag; out_valid/out_ready, result, carry, overflow_flag,
//   negative, zero, out_tag. Latency STAGES cycles, one op per cycle.
module pipelined_fixed_adder
    import fixed_point_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_subtract,
    input  logic             saturate,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow_flag,
    output logic             negative,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG = WIDTH / STAGES;

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(fx_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(fx_min(WIDTH));

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_fixed_adder: WIDTH must be a multiple of STAGES");
    end

    // Whole pipe advances together; output slot frees when taken.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    fx_flags_t flags_q;
    assign carry         = flags_q.carry;
    assign overflow_flag = flags_q.overflow;
    assign negative      = flags_q.negative;
    assign zero          = flags_q.zero;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [SEG-1:0]   sa;
        logic [SEG-1:0]   sb;
        logic [SEG-1:0]   sum;
        logic             ci;
        logic             co;
        logic             sat;
        logic             vld;
        logic [TAG_W-1:0] tag;

        // Slice operands come from the ports for stage 0, else from
        // the skewed upper-operand registers of the previous stage.
        if (k == 0) begin : g_src
            assign sa  = a[SEG-1:0];
            assign sb  = b[SEG-1:0] ^ {SEG{is_subtract}};
            assign ci  = is_subtract;
            assign sat = saturate;
            assign tag = in_tag;
            assign vld = in_valid;
        end else begin : g_src
            assign sa  = stg[k-1].g_reg.ah_q[SEG-1:0];
            assign sb  = stg[k-1].g_reg.bh_q[SEG-1:0];
            assign ci  = stg[k-1].g_reg.c_q;
            assign sat = stg[k-1].g_reg.sat_q;
            assign tag = stg[k-1].g_reg.tag_q;
            assign vld = stg[k-1].g_reg.v_q;
        end

        adder_segment #(
            .SEG(SEG)
        ) u_seg (
            .a  (sa),
            .b  (sb),
            .ci (ci),
            .sum(sum),
            .co (co)
        );

        if (k < STAGES - 1) begin : g_reg
            localparam int LO = (k + 1) * SEG;
            localparam int HI = WIDTH - LO;

            logic [LO-1:0]    lo_d;
            logic [LO-1:0]    lo_q;
            logic [HI-1:0]    ah_d;
            logic [HI-1:0]    bh_d;
            logic [HI-1:0]    ah_q;
            logic [HI-1:0]    bh_q;
            logic             c_q;
            logic             sat_q;
            logic             v_q;
            logic [TAG_W-1:0] tag_q;

            if (k == 0) begin : g_in
                assign lo_d = sum;
                assign ah_d = a[WIDTH-1:SEG];
                assign bh_d = b[WIDTH-1:SEG] ^ {HI{is_subtract}};
            end else begin : g_in
                assign lo_d = {sum, stg[k-1].g_reg.lo_q};
                assign ah_d = stg[k-1].g_reg.ah_q[WIDTH-k*SEG-1:SEG];
                assign bh_d = stg[k-1].g_reg.bh_q[WIDTH-k*SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lo_q  <= '0;
                    ah_q  <= '0;
                    bh_q  <= '0;
                    c_q   <= 1'b0;
                    sat_q <= 1'b0;
                    v_q   <= 1'b0;
                    tag_q <= '0;
                end else if (en) begin
                    lo_q  <= lo_d;
                    ah_q  <= ah_d;
                    bh_q  <= bh_d;
                    c_q   <= co;
                    sat_q <= sat;
                    v_q   <= vld;
                    tag_q <= tag;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] raw;
            logic [WIDTH-1:0] res;
            logic             ovf;
            logic             neg;

            if (k == 0) begin : g_raw
                assign raw = sum;
            end else begin : g_raw
                assign raw = {sum, stg[k-1].g_reg.lo_q};
            end

            // Top slice holds the MSBs of a, inverted b and raw sum.
            assign ovf = (sa[SEG-1] == sb[SEG-1]) &&
                         (sum[SEG-1] != sa[SEG-1]);
            assign neg = sum[SEG-1] ^ ovf;
            assign res = (sat && ovf) ? (neg ? SAT_MIN : SAT_MAX) : raw;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    result    <= '0;
                    flags_q   <= '0;
                    out_tag   <= '0;
                end else if (en) begin
                    out_valid        <= vld;
                    result           <= res;
                    flags_q.carry    <= co;
                    flags_q.overflow <= ovf;
                    flags_q.negative <= neg;
                    flags_q.zero     <= (res == '0);
                    out_tag          <= tag;
                end
            end
        end
    end

endmodule
